// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the shared FIFO memory: round-robin producer
// arbitration with burst locking, write pointer and registered full flag.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                         wclk,
    input  logic                         wrst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic [ADDR_SIZE:0]           wq2_rptr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [DATA_SIZE-1:0]         wdata,
    output logic [ADDR_SIZE-1:0]         waddr,
    output logic                         wclk_en,
    output logic [ADDR_SIZE:0]           wptr,
    output logic                         wfull
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [IW-1:0]       rr_ptr, rr_nxt;
    logic [3:0]          cnt, cnt_nxt, cnt_inc;
    logic [IW-1:0]       rr_win, win, win_inc;
    logic                rr_hit, locked, win_vld, accept;
    logic [ADDR_SIZE:0]  wbin, wbin_next, wgray_next, rptr_full;

    // Scan downward so the lowest offset from rr_ptr is the last writer.
    always_comb begin
        logic [IW-1:0] idx;
        rr_hit = 1'b0;
        rr_win = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                rr_hit = 1'b1;
                rr_win = idx;
            end
        end
    end

    always_comb begin
        locked  = (state == LOCK) && req[owner];
        win_vld = locked || rr_hit;
        win     = locked ? owner : rr_win;
        win_inc = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        accept  = !wfull && win_vld;
        cnt_inc = cnt + 4'd1;
    end

    always_comb begin
        gnt     = '0;
        wdata   = '0;
        wclk_en = accept;
        if (accept) begin
            gnt   = NUM_REQ'(1) << win;
            wdata = req_data[win*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        rr_nxt    = rr_ptr;
        unique case (1'b1)
            accept && locked: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == 4'(MAX_BURST))
                    state_nxt = IDLE;
            end
            accept && !locked: begin
                owner_nxt = win;
                cnt_nxt   = 4'd1;
                rr_nxt    = win_inc;
                state_nxt = (MAX_BURST > 1) ? LOCK : IDLE;
            end
            !accept && !wfull && (state == LOCK): begin
                state_nxt = IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wclk_en};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rptr_full  = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                      wq2_rptr[ADDR_SIZE-2:0]};
        waddr      = wbin[ADDR_SIZE-1:0];
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
            rr_ptr <= rr_nxt;
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= (wgray_next == rptr_full);
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the shared FIFO memory. Arbitrates up to `NUM_REQ` producers onto the single memory write port, using round-robin selection with optional fixed-length burst locking. It owns the write pointer (binary address plus Gray pointer for the read-domain synchronizer) and the registered full flag. It sits in the `wclk` domain between the producers and the memory's `wdata`/`waddr`/`wclk_en`/`wfull` inputs.

## Interface
- `DATA_SIZE`, 8, width of each data beat
- `ADDR_SIZE`, 4, memory address width; depth = 2^`ADDR_SIZE`
- `NUM_REQ`, 4, number of producers (2..8)
- `MAX_BURST`, 4, maximum consecutive beats per grant (1..15; 1 = pure round-robin)

Ports:
- `wclk`  in  1  write clock; all state on rising edge. One clock.
- `wrst_n`  in  1  asynchronous active-low reset.
- `req`  in  `NUM_REQ`  per-producer beat request; level, held until granted.
- `req_data`  in  `NUM_REQ`*`DATA_SIZE`  producer i data at bits [i*`DATA_SIZE` +: `DATA_SIZE`].
- `wq2_rptr`  in  `ADDR_SIZE`+1  read pointer, Gray-coded, already synchronized into `wclk`.
- `gnt`  out  `NUM_REQ`  one-hot, combinational; high marks the beat accepted on this edge.
- `wdata`  out  `DATA_SIZE`  `req_data` slice of the winner; 0 when no grant.
- `waddr`  out  `ADDR_SIZE`  low bits of the binary write pointer.
- `wclk_en`  out  1  high in any cycle with a grant.
- `wptr`  out  `ADDR_SIZE`+1  registered Gray write pointer.
- `wfull`  out  1  registered full flag.

## Operation
- **Accept condition:** a beat is accepted when `wfull`=0 and the selected winner's `req`=1.
  - `wclk_en` = |`gnt`.
  - While `wfull`=1: `gnt`=0, no state changes except `wfull` recompute.
- **Winner selection:**
  - In LOCK with `req[owner]`=1, the winner is `owner`, even if other producers request.
  - Otherwise the winner is the first set `req` bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
- **State machine** (state IDLE/LOCK, `owner`, `cnt` 4b, `rr_ptr`):
  - IDLE, accept of w:
    - `owner`←w, `cnt`←1, `rr_ptr`←(w+1) mod `NUM_REQ`.
    - Next state is LOCK if `MAX_BURST`>1, else IDLE.
  - LOCK, owner beat accepted:
    - `cnt`←`cnt`+1.
    - If `cnt`+1==`MAX_BURST`, go to IDLE.
  - LOCK, `req[owner]`=0 and another producer w wins: treat as a new IDLE accept of w in the same cycle (no bubble).
  - LOCK, `req[owner]`=0 and no other request: go to IDLE. `rr_ptr` stays at `owner`+1.
  - LOCK with `wfull`=1: hold state and `cnt` unchanged; the burst resumes when `wfull` clears.
- **Pointer arithmetic** (`ADDR_SIZE`+1 bits, wraps naturally):
  - `wbin_next` = `wbin` + `wclk_en`.
  - `wgray_next` = `wbin_next` ^ (`wbin_next`>>1).
  - `waddr` = `wbin`[`ADDR_SIZE`-1:0].
- **Full:** `wfull` ← (`wgray_next` == {~`wq2_rptr`[top two bits], `wq2_rptr`[remaining bits]}). Clears on the first edge after `wq2_rptr` advances.
- **Reset** (asynchronous, any time including mid-burst):
  - `wbin`=0, `wptr`=0, `wfull`=0, state IDLE, `owner`=0, `cnt`=0, `rr_ptr`=0.
  - `gnt`/`wclk_en`/`wdata` then follow `req` combinationally.
  - A beat in flight during reset is lost. The producer still sees `req` un-granted and must re-present the beat.

## Timing
- **Combinational path:** `req` → `gnt`/`wclk_en`/`wdata` in the same cycle. The memory write and the pointer increment occur on the same rising edge.
- **Latency:** `waddr` and `wptr` advance one edge after each accept.
- **Full assertion:** `wfull` asserts on the edge that writes the last free slot. No accept is possible in the following cycle.
- **Producer handshake:** a producer sees `gnt[i]`=1 and may change `req_data`/`req` after that edge.
- **Throughput:** 1 beat/cycle while not full.

## Test plan
- **Reset:** `wrst_n`=0 with `req`=4'b1111 → `wptr`=0, `wfull`=0. Release reset → first `gnt`=4'b0001, `waddr`=0.
- **Fill to full:** `MAX_BURST`=1, `req`=4'b0001 held, `wq2_rptr`=0 → 16 grants, `waddr` 0..15. `wfull`=1 after the 16th edge, `wptr`=5'b11000, `gnt`=0 thereafter.
- **Round-robin:** `MAX_BURST`=1, `req`=4'b1111 → grant order 0,1,2,3,0. Dropping `req[1]` → order skips 1.
- **Burst lock:** `MAX_BURST`=4, `req`=4'b0011 → 0,0,0,0,1,1,1,1,0. Dropping `req[0]` after its 2nd beat → `gnt`=4'b0010 on the next cycle.
- **Wrap and full clear:** write 16, then advance `wq2_rptr` Gray to 5'b00001 → `wfull` clears next edge. The next write lands at `waddr`=0, and the pointer wraps correctly through 31→0.
- **Reset mid-burst:** assert `wrst_n`=0 at `cnt`=2 → `wptr`=0 immediately. After release, round-robin restarts from producer 0.
